// File: rtl/pulse_gen_scheduler.sv
// pulse_gen_scheduler: round-robin sharing of one pulse_generator between two requesters
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req0/pattern0/reps0     requester 0 job (request held until gnt0)
//   req1/pattern1/reps1     requester 1 job (request held until gnt1)
//   gnt0, gnt1              one-cycle accept pulses
//   pg_in, pg_load          drive the generator's in / load_flag
//   pulse_en                qualifies the generator's serial output for reps*WIDTH cycles
//   owner, busy             current/last job id, job in progress
//   done, done_id           one-cycle completion pulse and its requester id
module pulse_gen_scheduler #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] pattern0,
    input  logic [CNT_W-1:0] reps0,
    input  logic             req1,
    input  logic [WIDTH-1:0] pattern1,
    input  logic [CNT_W-1:0] reps1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] pg_in,
    output logic             pg_load,
    output logic             pulse_en,
    output logic             owner,
    output logic             busy,
    output logic             done,
    output logic             done_id
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    typedef enum logic [2:0] {IDLE, LOAD, FILL, RUN, DONE} state_t;
    state_t state, state_n;
    logic ptr, win, accept, last;
    logic [BW-1:0] bit_cnt;
    logic [CNT_W-1:0] rep_cnt, reps_w;
    logic [WIDTH-1:0] pat_w;
    // ptr=0 favours req0 on a tie, ptr=1 favours req1
    always_comb begin
        win    = req1 & (~req0 | ptr);
        accept = (state == IDLE) & (req0 | req1);
        pat_w  = win ? pattern1 : pattern0;
        reps_w = win ? reps1 : reps0;
        last   = (bit_cnt == BIT_LAST) & (rep_cnt == CNT_W'(1));
        state_n = state;
        unique case (state)
            IDLE:    state_n = accept ? ((reps_w == '0) ? DONE : LOAD) : IDLE;
            LOAD:    state_n = FILL;
            FILL:    state_n = RUN;
            RUN:     state_n = last ? DONE : RUN;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // outputs are registered from the next state so they line up with it
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            bit_cnt  <= '0;
            rep_cnt  <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            pg_in    <= '0;
            pg_load  <= 1'b0;
            pulse_en <= 1'b0;
            owner    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
        end else begin
            state    <= state_n;
            gnt0     <= accept & ~win;
            gnt1     <= accept & win;
            pg_load  <= state_n == LOAD;
            pulse_en <= state_n == RUN;
            busy     <= state_n != IDLE;
            done     <= state_n == DONE;
            done_id  <= (state_n == DONE) & (accept ? win : owner);
            if (accept) begin
                owner   <= win;
                ptr     <= ~win;
                rep_cnt <= reps_w;
                bit_cnt <= '0;
            end
            // pg_in only changes when a load actually follows
            if (accept && reps_w != '0)
                pg_in <= pat_w;
            if (state == RUN) begin
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                if (bit_cnt == BIT_LAST)
                    rep_cnt <= rep_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pulse_gen_scheduler.sv
// tb_pulse_gen_scheduler: directed checks of the scheduler driving a shifter model
module tb_pulse_gen_scheduler;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] pattern0 = '0, pattern1 = '0;
    logic [7:0]  reps0 = '0, reps1 = '0;
    logic        gnt0, gnt1, pg_load, pulse_en, owner, busy, done, done_id;
    logic [15:0] pg_in;
    logic [15:0] pg_r;
    logic        o;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pulse_gen_scheduler #(.WIDTH(16), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .pattern0(pattern0), .reps0(reps0),
        .req1(req1), .pattern1(pattern1), .reps1(reps1),
        .gnt0(gnt0), .gnt1(gnt1), .pg_in(pg_in), .pg_load(pg_load),
        .pulse_en(pulse_en), .owner(owner), .busy(busy),
        .done(done), .done_id(done_id)
    );

    // pulse_generator: circular shifter with registered serial output
    always_ff @(posedge clock) begin
        if (pg_load) pg_r <= pg_in;
        else begin
            pg_r <= {pg_r[14:0], pg_r[15]};
            o    <= pg_r[15];
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {gnt0, gnt1, pg_load, pulse_en, owner, busy, done, done_id, pg_in}, 32'd0);
    endtask

    task automatic wait_gnt(input logic id);
        int n = 0;
        while (((id ? gnt1 : gnt0) !== 1'b1) && n < 40) begin
            step();
            n++;
        end
        chk("gnt_seen", {gnt1, gnt0}, id ? 32'd2 : 32'd1);
    endtask

    // entered in the grant cycle; leaves in the first IDLE cycle after done
    task automatic run_job(input logic id, input logic [15:0] pat, input int reps, input logic clr);
        chk("grant_owner", owner, id);
        chk("grant_busy", busy, 1);
        chk("grant_pulse_en", pulse_en, 0);
        if (id) req1 = 1'b0; else req0 = 1'b0;
        if (reps == 0) begin
            chk("zero_done", {done, done_id, pg_load, pulse_en}, {1'b1, id, 2'b00});
            if (clr) begin req0 = 1'b0; req1 = 1'b0; end
            step();
            chk("zero_idle", {busy, done, pulse_en, pg_load}, 0);
        end else begin
            chk("load_ctl", {pg_load, done}, 2'b10);
            chk("load_pg_in", pg_in, pat);
            step();
            chk("fill_ctl", {pg_load, pulse_en, gnt1, gnt0, busy}, 5'b00001);
            for (int r = 0; r < reps; r++)
                for (int k = 0; k < 16; k++) begin
                    step();
                    chk("run_ctl", {pulse_en, busy, done, gnt1, gnt0, pg_load}, 6'b110000);
                    chk("run_o", o, pat[15-k]);
                end
            step();
            if (clr) begin req0 = 1'b0; req1 = 1'b0; end
            chk("done_ctl", {done, done_id, pulse_en, busy, pg_load}, {1'b1, id, 3'b010});
            step();
            chk("after_done", {busy, done, pulse_en}, 0);
        end
    endtask

    initial begin
        step();
        step();
        chk_zero("reset_state");
        reset = 1'b0;
        // T1
        req0 = 1'b1; pattern0 = 16'h8001; reps0 = 8'd1;
        wait_gnt(0);
        run_job(0, 16'h8001, 1, 0);
        // T2: pointer must be back on req0 after reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0 = 1'b1; pattern0 = 16'h1234; reps0 = 8'd1;
        req1 = 1'b1; pattern1 = 16'hC3C3; reps1 = 8'd1;
        wait_gnt(0);
        run_job(0, 16'h1234, 1, 0);
        wait_gnt(1);
        run_job(1, 16'hC3C3, 1, 0);
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(0);
        run_job(0, 16'h1234, 1, 0);
        wait_gnt(1);
        run_job(1, 16'hC3C3, 1, 0);
        // T3
        req1 = 1'b1; pattern1 = 16'hA5A5; reps1 = 8'd3;
        wait_gnt(1);
        run_job(1, 16'hA5A5, 3, 0);
        // T4
        req0 = 1'b1; pattern0 = 16'hFFFF; reps0 = 8'd0;
        wait_gnt(0);
        run_job(0, 16'hFFFF, 0, 0);
        chk("zero_pg_in_held", pg_in, 16'hA5A5);
        // T5: reset in RUN cycle 5
        req0 = 1'b1; pattern0 = 16'hF00F; reps0 = 8'd2;
        wait_gnt(0);
        req0 = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        chk("run5_pulse_en", pulse_en, 1);
        reset = 1'b1;
        step();
        chk_zero("reset_mid_run");
        reset = 1'b0;
        req1 = 1'b1; pattern1 = 16'h0FF0; reps1 = 8'd1;
        wait_gnt(1);
        run_job(1, 16'h0FF0, 1, 0);
        // reset in LOAD must restore the req0-favouring pointer
        req0 = 1'b1; pattern0 = 16'h5555; reps0 = 8'd1;
        wait_gnt(0);
        req0 = 1'b0;
        reset = 1'b1;
        step();
        chk_zero("reset_in_load");
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; pattern1 = 16'h00FF;
        wait_gnt(0);
        run_job(0, 16'h5555, 1, 0);
        wait_gnt(1);
        run_job(1, 16'h00FF, 1, 0);
        // T6: req1 waits out job 0; req0 withdrawn before any grant
        req0 = 1'b1; pattern0 = 16'h8421; reps0 = 8'd1;
        wait_gnt(0);
        req1 = 1'b1; pattern1 = 16'h7E7E; reps1 = 8'd1;
        run_job(0, 16'h8421, 1, 0);
        wait_gnt(1);
        req0 = 1'b1;
        run_job(1, 16'h7E7E, 1, 1);
        for (int i = 0; i < 4; i++) begin
            chk("withdrawn_req0", {gnt0, gnt1, busy}, 0);
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
